// File: rtl/m_lfsr_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : m_lfsr_pkg
//  Brief    : Shared constants for the 32-bit LFSR generator/checker pair:
//             register width, feedback taps, lock-up value, checker states.
//  Revision : 1.0  initial release
// ============================================================================
package m_lfsr_pkg;

   // Register width and feedback taps (shift left, feedback into the LSB)
   localparam int LFSR_W = 32;
   localparam int TAP_A  = 31;
   localparam int TAP_B  = 6;
   localparam int TAP_C  = 5;
   localparam int TAP_D  = 1;

   // The all-zero state never leaves itself, so it can never be a valid seed
   localparam logic [LFSR_W-1:0] LOCKUP = 32'h0;

   // Number of stream bits needed to fill the register
   localparam int SEED_LEN = LFSR_W;

   typedef enum logic {
      SEED  = 1'b0,
      CHECK = 1'b1
   } chk_state_e;

   // Feedback bit, which is also the next bit the generator emits
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
   endfunction

endpackage
`default_nettype wire

// File: rtl/m_lfsr_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : m_lfsr_checker_if
//  Brief    : Stream input and status output bundle of the LFSR checker.
//             master = stream source / status consumer, slave = checker.
//  Revision : 1.0  initial release
// ============================================================================
interface m_lfsr_checker_if #(
   parameter int ERR_CNT_W = 16
);
   import m_lfsr_pkg::*;

   logic                 w_valid;
   logic                 w_bit;
   logic                 w_clr_cnt;
   logic                 o_locked;
   logic                 o_err;
   logic                 o_lost;
   logic [ERR_CNT_W-1:0] o_err_cnt;

   modport master (
      output w_valid, w_bit, w_clr_cnt,
      input  o_locked, o_err, o_lost, o_err_cnt
   );

   modport slave (
      input  w_valid, w_bit, w_clr_cnt,
      output o_locked, o_err, o_lost, o_err_cnt
   );

endinterface
`default_nettype wire

// File: rtl/m_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module   : m_lfsr_checker
//  Brief    : Self-synchronising checker for the 32-bit LFSR bit stream.
//             Seeds its register from 32 received bits, then free-runs on
//             its own prediction and flags every received bit that differs.
//             Too many errors inside one window drops lock and reseeds.
//  Revision : 1.0  initial release
// ============================================================================
module m_lfsr_checker
   import m_lfsr_pkg::*;
#(
   parameter int ERR_CNT_W   = 16,
   parameter int LOSS_WIN    = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic              clk,
   input  logic              w_rst,
   m_lfsr_checker_if.slave   bus
);

   localparam int SEED_W = $clog2(SEED_LEN);
   localparam int WIN_W  = $clog2(LOSS_WIN + 1);
   localparam int THR_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_LEN - 1);
   localparam logic [WIN_W-1:0]  WIN_END   = WIN_W'(LOSS_WIN);
   localparam logic [THR_W-1:0]  THR_HIT   = THR_W'(LOSS_THRESH);

   chk_state_e           state_q,   state_d;
   logic [LFSR_W-1:0]    r_q,       r_d;
   logic [SEED_W-1:0]    seed_cnt_q, seed_cnt_d;
   logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
   logic [THR_W-1:0]     win_err_q, win_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 locked_q,  locked_d;
   logic                 err_q,     err_d;
   logic                 lost_q,    lost_d;

   logic                 pred;
   logic                 mis;
   logic [WIN_W-1:0]     win_cnt_inc;
   logic [THR_W-1:0]     win_err_inc;

   // Prediction from the current register and the window counters as they
   // would stand after this bit is counted
   assign pred        = lfsr_fb(r_q);
   assign mis         = bus.w_bit ^ pred;
   assign win_cnt_inc = win_cnt_q + WIN_W'(1);
   assign win_err_inc = win_err_q + THR_W'(mis);

   // Next-state logic: seeding, prediction/compare and loss-of-lock windows
   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      seed_cnt_d = seed_cnt_q;
      win_cnt_d  = win_cnt_q;
      win_err_d  = win_err_q;
      err_cnt_d  = err_cnt_q;
      err_d      = 1'b0;
      lost_d     = 1'b0;

      if (bus.w_valid) begin
         if (state_q == SEED) begin
            r_d = {r_q[LFSR_W-2:0], bus.w_bit};
            if (seed_cnt_q == SEED_LAST) begin
               // A full register of zeros would predict zeros forever; reseed
               seed_cnt_d = '0;
               if (r_d != LOCKUP) begin
                  state_d = CHECK;
               end
            end else begin
               seed_cnt_d = seed_cnt_q + SEED_W'(1);
            end
         end else begin
            // Shift in the prediction so a corrupted bit never pollutes r
            r_d   = {r_q[LFSR_W-2:0], pred};
            err_d = mis;
            if (mis && (err_cnt_q != '1)) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            // Threshold is tested before the window end, so loss wins a tie
            if (win_err_inc == THR_HIT) begin
               state_d    = SEED;
               lost_d     = 1'b1;
               seed_cnt_d = '0;
               win_cnt_d  = '0;
               win_err_d  = '0;
            end else if (win_cnt_inc == WIN_END) begin
               win_cnt_d  = '0;
               win_err_d  = '0;
            end else begin
               win_cnt_d  = win_cnt_inc;
               win_err_d  = win_err_inc;
            end
         end
      end

      // Clear takes priority over a same-cycle increment
      if (bus.w_clr_cnt) begin
         err_cnt_d = '0;
      end

      locked_d = (state_d == CHECK);
   end

   // State and registered outputs, asynchronously reset
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         state_q    <= SEED;
         r_q        <= '0;
         seed_cnt_q <= '0;
         win_cnt_q  <= '0;
         win_err_q  <= '0;
         err_cnt_q  <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         seed_cnt_q <= seed_cnt_d;
         win_cnt_q  <= win_cnt_d;
         win_err_q  <= win_err_d;
         err_cnt_q  <= err_cnt_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         lost_q     <= lost_d;
      end
   end

   assign bus.o_locked  = locked_q;
   assign bus.o_err     = err_q;
   assign bus.o_lost    = lost_q;
   assign bus.o_err_cnt = err_cnt_q;

endmodule
`default_nettype wire
